// File: rtl/vga_plot_adapter.sv
// vga_plot_adapter: plot-addressed framebuffer with a hardware clear FSM and
// continuous VGA scan-out, each framebuffer pixel shown as a SCALE x SCALE block.
module vga_plot_adapter #(
  parameter int RES_W       = 160,
  parameter int RES_H       = 120,
  parameter int COLOUR_BITS = 3,
  parameter int DAC_BITS    = 10,
  parameter int SCALE       = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int BG_COLOUR   = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic [10:0]            x,
  input  logic [10:0]            y,
  input  logic                   plot,
  input  logic                   clear,
  output logic                   busy,
  output logic [DAC_BITS-1:0]    VGA_R,
  output logic [DAC_BITS-1:0]    VGA_G,
  output logic [DAC_BITS-1:0]    VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK,
  output logic                   VGA_SYNC,
  output logic                   VGA_CLK
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CB      = COLOUR_BITS / 3;
  localparam int WORDS   = RES_W * RES_H;
  localparam int AW      = $clog2(WORDS);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SH      = $clog2(SCALE);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;

  logic                   phase, en, vis, we, plot_ok;
  logic                   hs_p, vs_p, bl_p;
  logic [HW-1:0]          h;
  logic [VW-1:0]          v;
  logic [AW-1:0]          caddr, ra, wa;
  logic [COLOUR_BITS-1:0] wd, rd;
  logic [COLOUR_BITS-1:0] mem [WORDS];
  logic [DAC_BITS-1:0]    r_w, g_w, b_w;

  assign en       = ~phase;
  assign VGA_CLK  = phase;
  assign VGA_SYNC = 1'b0;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      phase <= 1'b0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= ~phase;
      if (en) begin
        h <= (h == HW'(H_TOTAL - 1)) ? '0 : h + 1'b1;
        if (h == HW'(H_TOTAL - 1))
          v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end
    end

  always_comb begin
    vis     = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    ra      = vis ? AW'(32'(v >> SH) * RES_W + 32'(h >> SH)) : '0;
    plot_ok = plot && (x < 11'(RES_W)) && (y < 11'(RES_H)) && !busy;
    we      = busy || plot_ok;
    wa      = busy ? caddr : AW'(32'(y) * RES_W + 32'(x));
    wd      = busy ? COLOUR_BITS'(BG_COLOUR) : colour;
  end

  // Read-before-write on a shared address falls out of the nonblocking update.
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
    if (en) rd <= mem[ra];
  end

  for (genvar i = 0; i < DAC_BITS; i++) begin : g_widen
    assign r_w[DAC_BITS-1-i] = rd[COLOUR_BITS-1-(i % CB)];
    assign g_w[DAC_BITS-1-i] = rd[2*CB-1-(i % CB)];
    assign b_w[DAC_BITS-1-i] = rd[CB-1-(i % CB)];
  end

  // Sync stages hold active-high pulses so a zeroed pipeline is inactive.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      hs_p      <= 1'b0;
      vs_p      <= 1'b0;
      bl_p      <= 1'b0;
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else if (en) begin
      hs_p      <= (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
      vs_p      <= (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
      bl_p      <= vis;
      VGA_HS    <= ~hs_p;
      VGA_VS    <= ~vs_p;
      VGA_BLANK <= bl_p;
      VGA_R     <= bl_p ? r_w : '0;
      VGA_G     <= bl_p ? g_w : '0;
      VGA_B     <= bl_p ? b_w : '0;
    end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= CLEAR;
      caddr <= '0;
      busy  <= 1'b1;
    end else if (state == CLEAR) begin
      if (caddr == AW'(WORDS - 1)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else
        caddr <= caddr + 1'b1;
    end else if (clear) begin
      state <= CLEAR;
      caddr <= '0;
      busy  <= 1'b1;
    end
endmodule

// File: tb/tb_vga_plot_adapter.sv
// tb_vga_plot_adapter: reduced-resolution bench; a time-based model predicts
// every pin from the clock count and a write log of the framebuffer.
module tb_vga_plot_adapter;
  localparam int W = 16, H = 12, S = 4, N = W * H, BG = 2, DB = 10, CB = 1;
  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
  localparam int VA = 48, VFP = 2, VSY = 2, VBP = 3, VT = VA + VFP + VSY + VBP;

  logic clock, resetn, plot, clear, busy;
  logic [2:0] colour;
  logic [10:0] x, y;
  logic [DB-1:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

  vga_plot_adapter #(
    .RES_W(W), .RES_H(H), .COLOUR_BITS(3), .DAC_BITS(DB), .SCALE(S),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .BG_COLOUR(BG)
  ) dut (
    .clock(clock), .resetn(resetn), .colour(colour), .x(x), .y(y),
    .plot(plot), .clear(clear), .busy(busy),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK)
  );

  always #5 clock = ~clock;

  typedef struct {int e; int a; int old;} wlog_t;
  wlog_t lg[$];
  int cur[N];
  int checks, errors, g, n, fill, eh, ev;
  logic ehs, evs, ebl, eclk, ebusy, eknown;
  logic [DB-1:0] er, eg, eb;

  function automatic logic [DB-1:0] widen(input logic [CB-1:0] c);
    logic [CB*DB-1:0] r;
    r = {DB{c}};
    return r[CB*DB-1 -: DB];
  endfunction

  task automatic wr(input int a, input int d);
    lg.push_back('{g, a, cur[a]});
    cur[a] = d;
    while (lg.size() > 0 && lg[0].e < g - 4) void'(lg.pop_front());
  endtask

  // One clock: apply the framebuffer rules to the inputs seen at this edge,
  // then predict the pins from the pixel being shown at this time.
  task automatic tick();
    int p, a, e, c;
    logic [2:0] cv;
    @(posedge clock);
    g++;
    if (!resetn) begin
      n = 0;
      fill = N;
    end else begin
      n++;
      if (fill > 0) begin
        wr(N - fill, BG);
        fill--;
      end else begin
        if (plot && x < W && y < H) wr(int'(y) * W + int'(x), int'(colour));
        if (clear) fill = N;
      end
    end
    ebusy = fill > 0;
    eclk = n[0];
    eknown = 1'b1;
    er = '0; eg = '0; eb = '0;
    if (n < 3) begin
      ehs = 1'b1; evs = 1'b1; ebl = 1'b0; eh = -1; ev = -1;
    end else begin
      p = (n - 3) / 2;
      eh = p % HT;
      ev = (p / HT) % VT;
      ehs = !(eh >= HA + HFP && eh < HA + HFP + HSY);
      evs = !(ev >= VA + VFP && ev < VA + VFP + VSY);
      ebl = eh < HA && ev < VA;
      if (ebl) begin
        a = (ev / S) * W + eh / S;
        e = g - (n[0] ? 2 : 3);
        c = cur[a];
        for (int i = lg.size() - 1; i >= 0; i--)
          if (lg[i].e >= e && lg[i].a == a) c = lg[i].old;
        eknown = c >= 0;
        cv = 3'(c);
        er = widen(cv[2]); eg = widen(cv[1]); eb = widen(cv[0]);
      end
    end
    #1;
  endtask

  task automatic wait_pix(input int ph, input int pv, output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * HT * VT && !ok; i++) begin
      tick();
      if (eh == ph && ev == pv) ok = 1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    checks += 8;
    if (VGA_HS !== 1'b1) begin errors++; $display("FAIL reset_hs got %0b want 1", VGA_HS); end
    if (VGA_VS !== 1'b1) begin errors++; $display("FAIL reset_vs got %0b want 1", VGA_VS); end
    if (VGA_BLANK !== 1'b0) begin errors++; $display("FAIL reset_blank got %0b want 0", VGA_BLANK); end
    if (VGA_R !== '0) begin errors++; $display("FAIL reset_r got %h want 0", VGA_R); end
    if ((VGA_G | VGA_B) !== '0) begin errors++; $display("FAIL reset_gb got %h/%h want 0", VGA_G, VGA_B); end
    if (VGA_CLK !== 1'b0) begin errors++; $display("FAIL reset_clk got %0b want 0", VGA_CLK); end
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
    if (VGA_SYNC !== 1'b0) begin errors++; $display("FAIL reset_sync got %0b want 0", VGA_SYNC); end
  endtask

  task automatic test_fill();
    int cnt = 0;
    resetn = 1'b1;
    do begin
      tick();
      cnt++;
      if (cnt == 50) begin
        clear = 1'b1; plot = 1'b1; x = 3; y = 3; colour = 3'd7;
      end else begin
        clear = 1'b0; plot = 1'b0;
      end
    end while (busy === 1'b1 && cnt < N + 50);
    checks++;
    if (cnt != N) begin errors++; $display("FAIL fill_len got %0d clocks want %0d", cnt, N); end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2 * HT * VT + 400; i++) begin
      tick();
      plot = 1'b0; clear = 1'b0;
      if (i % 4 == 0) begin
        plot = 1'b1;
        x = ($urandom % 8 == 0) ? 11'($urandom) : 11'($urandom_range(W + 3));
        y = ($urandom % 8 == 0) ? 11'($urandom) : 11'($urandom_range(H + 2));
        colour = 3'($urandom);
      end
      if (i == 5000) begin clear = 1'b1; plot = 1'b0; end
      checks += 5;
      if (VGA_HS !== ehs) begin errors++; $display("FAIL scan_hs h=%0d v=%0d got %0b want %0b", eh, ev, VGA_HS, ehs); end
      if (VGA_VS !== evs) begin errors++; $display("FAIL scan_vs h=%0d v=%0d got %0b want %0b", eh, ev, VGA_VS, evs); end
      if (VGA_BLANK !== ebl) begin errors++; $display("FAIL scan_blank h=%0d v=%0d got %0b want %0b", eh, ev, VGA_BLANK, ebl); end
      if (VGA_CLK !== eclk) begin errors++; $display("FAIL scan_clk got %0b want %0b", VGA_CLK, eclk); end
      if (busy !== ebusy) begin errors++; $display("FAIL scan_busy got %0b want %0b", busy, ebusy); end
      if (eknown) begin
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== {er, eg, eb})
          begin errors++; $display("FAIL scan_rgb h=%0d v=%0d got %h/%h/%h want %h/%h/%h", eh, ev, VGA_R, VGA_G, VGA_B, er, eg, eb); end
      end
    end
    plot = 1'b0;
  endtask

  task automatic test_corner();
    bit ok;
    int k = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do begin tick(); k++; end while (busy === 1'b1 && k < N + 10);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL corner_busy got %0b want 0", busy); end
    plot = 1'b1; x = 0; y = 0; colour = 3'b101;
    tick(); plot = 1'b0; repeat (3) tick();
    plot = 1'b1; x = W; y = 5; colour = 3'b111;
    tick(); plot = 1'b0; repeat (3) tick();
    plot = 1'b1; x = 3; y = H; colour = 3'b111;
    tick(); plot = 1'b0; repeat (3) tick();
    wait_pix(2, 1, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL corner_wait got timeout want pixel (2,1)"); end
    if ({VGA_R, VGA_G, VGA_B} !== {10'h3FF, 10'h000, 10'h3FF})
      begin errors++; $display("FAIL corner_rgb got %h/%h/%h want 3ff/000/3ff", VGA_R, VGA_G, VGA_B); end
    wait_pix(5, 1, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL neigh_wait got timeout want pixel (5,1)"); end
    if ({VGA_R, VGA_G, VGA_B} !== {10'h000, 10'h3FF, 10'h000})
      begin errors++; $display("FAIL neigh_rgb got %h/%h/%h want 000/3ff/000", VGA_R, VGA_G, VGA_B); end
    wait_pix(1, 25, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL oor_wait got timeout want pixel (1,25)"); end
    if ({VGA_R, VGA_G, VGA_B} !== {10'h000, 10'h3FF, 10'h000})
      begin errors++; $display("FAIL oor_rgb got %h/%h/%h want 000/3ff/000", VGA_R, VGA_G, VGA_B); end
  endtask

  task automatic test_blank();
    for (int r = 0; r < 3; r++) begin
      plot = 1'b1; x = W - 1; y = 11'(r); colour = 3'b111;
      tick(); plot = 1'b0; repeat (3) tick();
    end
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick();
      if (eh >= HA) begin
        checks++;
        if (VGA_BLANK !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== '0)
          begin errors++; $display("FAIL hblank h=%0d v=%0d got %0b %h/%h/%h want 0 000/000/000", eh, ev, VGA_BLANK, VGA_R, VGA_G, VGA_B); end
      end
      if (eh == HA - 1 && ev == 1) begin
        checks++;
        if (VGA_BLANK !== 1'b1 || VGA_R !== 10'h3FF)
          begin errors++; $display("FAIL edge_pix got %0b %h want 1 3ff", VGA_BLANK, VGA_R); end
      end
    end
  endtask

  task automatic test_sync();
    int hf[$], hr[$], vf[$], vr[$];
    logic ph, pv;
    ph = VGA_HS; pv = VGA_VS;
    for (int i = 0; i < 4 * HT * VT + 2000; i++) begin
      tick();
      if (ph && !VGA_HS) hf.push_back(g);
      if (!ph && VGA_HS && hf.size() > 0) hr.push_back(g);
      if (pv && !VGA_VS) vf.push_back(g);
      if (!pv && VGA_VS && vf.size() > 0) vr.push_back(g);
      ph = VGA_HS; pv = VGA_VS;
    end
    checks += 4;
    if (hf.size() < 2 || hr.size() < 1) begin errors++; $display("FAIL hs_seen got %0d falls want 2", hf.size()); end
    else begin
      if (hr[0] - hf[0] != 2 * HSY) begin errors++; $display("FAIL hs_width got %0d want %0d", hr[0] - hf[0], 2 * HSY); end
      if (hf[1] - hf[0] != 2 * HT) begin errors++; $display("FAIL hs_period got %0d want %0d", hf[1] - hf[0], 2 * HT); end
    end
    if (vf.size() < 2 || vr.size() < 1) begin errors++; $display("FAIL vs_seen got %0d falls want 2", vf.size()); end
    else begin
      if (vr[0] - vf[0] != 2 * VSY * HT) begin errors++; $display("FAIL vs_width got %0d want %0d", vr[0] - vf[0], 2 * VSY * HT); end
      if (vf[1] - vf[0] != 2 * VT * HT) begin errors++; $display("FAIL vs_period got %0d want %0d", vf[1] - vf[0], 2 * VT * HT); end
    end
  endtask

  task automatic test_midframe_reset();
    bit ok;
    int cnt = 0;
    wait_pix(5, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_wait got timeout want pixel (5,30)"); end
    resetn = 1'b0;
    #1;
    checks += 4;
    if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1) begin errors++; $display("FAIL mid_sync got %0b%0b want 11", VGA_HS, VGA_VS); end
    if (VGA_BLANK !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== '0) begin errors++; $display("FAIL mid_pix got %0b %h want 0 0", VGA_BLANK, VGA_R); end
    if (VGA_CLK !== 1'b0) begin errors++; $display("FAIL mid_clk got %0b want 0", VGA_CLK); end
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %0b want 1", busy); end
    repeat (2) tick();
    resetn = 1'b1;
    do begin tick(); cnt++; end while (VGA_VS === 1'b1 && cnt < 4 * HT * VT);
    checks++;
    if (cnt != 2 * (VA + VFP) * HT + 3)
      begin errors++; $display("FAIL mid_vs_delay got %0d clocks want %0d", cnt, 2 * (VA + VFP) * HT + 3); end
  endtask

  initial begin
    clock = 1'b0; resetn = 1'b0; plot = 1'b0; clear = 1'b0;
    x = '0; y = '0; colour = '0;
    checks = 0; errors = 0; g = 0; n = 0; fill = N;
    for (int i = 0; i < N; i++) cur[i] = -1;
    test_reset();
    test_fill();
    test_scan();
    test_corner();
    test_blank();
    test_sync();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_plot_adapter.md
VGA_PLOT_ADAPTER -- requirements
Module: vga_plot_adapter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RES_W, 160: framebuffer width in pixels.
- RES_H, 120: framebuffer height in pixels.
- COLOUR_BITS, 3: bits per stored pixel; a multiple of 3, split evenly R,G,B with R in the MSBs.
- DAC_BITS, 10: width of each VGA colour output.
- SCALE, 4: display pixels per framebuffer pixel in each axis; RES_W*SCALE SHALL equal H_ACTIVE and RES_H*SCALE SHALL equal V_ACTIVE.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixel periods.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines.
- BG_COLOUR, 0: fill value written by a clear.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: system clock (50 MHz nominal).
- resetn, in, 1: reset, asynchronous and active-low.
- colour, in, COLOUR_BITS: pixel value to plot.
- x, in, 11: plot column.
- y, in, 11: plot row.
- plot, in, 1: write request, sampled each clock.
- clear, in, 1: start a fill of the whole framebuffer with BG_COLOUR.
- busy, out, 1: clear in progress.
- VGA_R/VGA_G/VGA_B, out, DAC_BITS each: colour outputs.
- VGA_HS/VGA_VS, out, 1 each: sync outputs, active-low.
- VGA_BLANK, out, 1: high when the pixel is visible.
- VGA_SYNC, out, 1: tied to 0.
- VGA_CLK, out, 1: pixel clock, equal to clock/2.

Function
REQ-003 A pixel enable SHALL assert every second clock cycle; VGA_CLK SHALL toggle every clock and be low in the enable cycle.
REQ-004 The horizontal counter h SHALL count from 0 to H_TOTAL-1 (800 by default) on each pixel enable and then wrap to 0.
REQ-005 The vertical counter v SHALL advance when h wraps, count from 0 to V_TOTAL-1 (525 by default), and then wrap to 0.
REQ-006 Raw HS SHALL be 0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and 1 otherwise; VS SHALL follow the same rule on v.
REQ-007 Raw BLANK SHALL be 1 only when h<H_ACTIVE and v<V_ACTIVE.
REQ-008 The read address SHALL be (v/SCALE)*RES_W + (h/SCALE); SCALE is a power of two, so the divide is a right shift.
REQ-009 The framebuffer SHALL be a simple dual-port RAM of RES_W*RES_H words of COLOUR_BITS, with a registered read.
REQ-010 HS, VS and BLANK SHALL be delayed so they stay cycle-aligned with the RGB outputs; total latency from counter to pins is 2 pixel periods.
REQ-011 Each colour channel of CB=COLOUR_BITS/3 bits SHALL be widened to DAC_BITS by repeating its bits, MSB first, truncated to DAC_BITS.
REQ-012 VGA_R, VGA_G and VGA_B SHALL be 0 whenever the aligned BLANK is 0.
REQ-013 A write SHALL occur in any cycle with plot=1, x<RES_W, y<RES_H and busy=0, at address y*RES_W+x.
REQ-014 A plot with out-of-range coordinates, or during busy, SHALL be dropped silently.
REQ-015 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-016 The fill FSM SHALL have two states, IDLE and CLEAR:
- IDLE->CLEAR on clear=1; the address counter loads 0.
- CLEAR writes BG_COLOUR at one address per clock, then increments.
- CLEAR->IDLE after writing address RES_W*RES_H-1.
- busy=1 exactly while in CLEAR.
REQ-017 A clear asserted while in CLEAR SHALL be ignored; the fill does not restart.
REQ-018 The scan-out SHALL run continuously and SHALL never stall for plots or clears.

Reset
REQ-019 When resetn=0 the block SHALL set:
- h=0, v=0, pixel enable phase 0, VGA_CLK=0;
- VGA_HS=1, VGA_VS=1, VGA_BLANK=0, RGB=0, alignment pipeline zeroed;
- FSM in CLEAR with address 0, busy=1.
REQ-020 On resetn release the FSM SHALL fill the whole framebuffer, taking RES_W*RES_H clocks (19200 by default), then enter IDLE.
REQ-021 Reset asserted mid-clear or mid-frame SHALL restart all of the above from the reset values.

Verification
REQ-022 Release reset and count clocks: busy falls after exactly 19200 clocks; HS low pulse is 192 clocks wide with period 1600 clocks; VS low is 2 lines with period 525 lines.
REQ-023 After the clear, plot colour=3'b101 at (0,0) -> first visible 4x4 display block shows R=10'h3FF, G=0, B=0x3FF, and neighbouring pixels are 0.
REQ-024 Plot at x=160, y=5 and at x=3, y=120 -> no RAM change, and display remains BG_COLOUR.
REQ-025 Plot at (10,10) while busy=1 -> write dropped; pulsing clear mid-fill does not extend busy.
REQ-026 Scan h=640..799 -> BLANK=0 and RGB=0, even over non-zero RAM contents.
REQ-027 Assert resetn=0 mid-frame at v=300 -> outputs take reset values immediately, and the next VS pulse follows 490 lines after release.
